// File: rtl/seq_bcd_display_if.sv
// Handshake and display bus between the ALU result path and seq_bcd_display.
interface seq_bcd_display_if #(
    parameter int unsigned DW = 8,
    parameter int unsigned ND = 3
);
    logic            i_start;
    logic [DW-1:0]   i_bin;
    logic            o_busy;
    logic            o_done;
    logic [7*ND-1:0] o_seg;
    logic [6:0]      o_sign_seg;

    modport master (
        output i_start, i_bin,
        input  o_busy, o_done, o_seg, o_sign_seg
    );

    modport slave (
        input  i_start, i_bin,
        output o_busy, o_done, o_seg, o_sign_seg
    );
endinterface

// File: rtl/seq_bcd_display.sv
// Sequential signed-binary to ND-digit 7-segment driver (iterative double-dabble).
// Optional leading-zero blanking when SEQ_BCD_LZB_EN is defined.
module seq_bcd_display #(
    parameter int unsigned DW             = 8,
    parameter int unsigned ND             = 3,
    parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    seq_bcd_display_if.slave  bus
);
    localparam int unsigned BW = 4 * ND;
    localparam int unsigned SW = 7 * ND;
    localparam int unsigned CW = (DW > 1) ? $clog2(DW) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_CONV  = 2'd1;
    localparam logic [1:0] S_LATCH = 2'd2;

    localparam logic [6:0] SEG_MINUS = 7'h40;
    localparam logic [6:0] SEG_BLANK = 7'h00;
    localparam logic [6:0] PIN_BLANK = SEG_ACTIVE_LOW ? ~SEG_BLANK : SEG_BLANK;

    function automatic logic [63:0] pow10(input int unsigned n);
        logic [63:0] r;
        r = 64'd1;
        for (int unsigned k = 0; k < n; k++) r = r * 64'd10;
        return r;
    endfunction

    localparam bit CFG_OK = (DW >= 2) && (DW <= 32) && (ND >= 1) &&
                            (pow10(ND) > (64'd1 << (DW - 1)));

    generate
        if (!CFG_OK) begin : g_cfg_err
            $error("seq_bcd_display: illegal DW/ND (need 2<=DW<=32 and 10^ND > 2^(DW-1))");
        end
    endgenerate

    // Active-high segment pattern {g,f,e,d,c,b,a}; out-of-range nibbles show blank.
    function automatic logic [6:0] seg_enc(input logic [3:0] d);
        case (d)
            4'd0:    return 7'h3F;
            4'd1:    return 7'h06;
            4'd2:    return 7'h5B;
            4'd3:    return 7'h4F;
            4'd4:    return 7'h66;
            4'd5:    return 7'h6D;
            4'd6:    return 7'h7D;
            4'd7:    return 7'h07;
            4'd8:    return 7'h7F;
            4'd9:    return 7'h6F;
            default: return SEG_BLANK;
        endcase
    endfunction

    function automatic logic [6:0] seg_pol(input logic [6:0] s);
        return SEG_ACTIVE_LOW ? ~s : s;
    endfunction

    logic [1:0]    state_q, state_nxt;
    logic          sign_q, sign_nxt;
    logic [DW-1:0] mag_q, mag_nxt;
    logic [BW-1:0] bcd_q, bcd_nxt;
    logic [CW-1:0] cnt_q, cnt_nxt;
    logic [SW-1:0] seg_q, seg_nxt;
    logic [6:0]    sign_seg_q, sign_seg_nxt;
    logic          busy_q, busy_nxt;
    logic          done_q, done_nxt;

    logic          accept;
    logic [BW-1:0] bcd_adj;
    logic [3:0]    dig;
    logic [6:0]    code;
    logic [ND-1:0] lzb_blank;
    logic          lz_run;

    // State and datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            sign_q     <= 1'b0;
            mag_q      <= '0;
            bcd_q      <= '0;
            cnt_q      <= '0;
            seg_q      <= {ND{PIN_BLANK}};
            sign_seg_q <= PIN_BLANK;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_nxt;
            sign_q     <= sign_nxt;
            mag_q      <= mag_nxt;
            bcd_q      <= bcd_nxt;
            cnt_q      <= cnt_nxt;
            seg_q      <= seg_nxt;
            sign_seg_q <= sign_seg_nxt;
            busy_q     <= busy_nxt;
            done_q     <= done_nxt;
        end
    end

    // Next-state, conversion step and output latch
    always_comb begin
        state_nxt    = state_q;
        sign_nxt     = sign_q;
        mag_nxt      = mag_q;
        bcd_nxt      = bcd_q;
        cnt_nxt      = cnt_q;
        seg_nxt      = seg_q;
        sign_seg_nxt = sign_seg_q;
        busy_nxt     = busy_q;
        done_nxt     = 1'b0;
        accept       = 1'b0;
        bcd_adj      = bcd_q;
        dig          = 4'd0;
        code         = SEG_BLANK;
        lzb_blank    = '0;
        lz_run       = 1'b1;

        case (state_q)
            S_IDLE: begin
                busy_nxt = 1'b0;
                accept   = bus.i_start;
            end
            S_CONV: begin
                busy_nxt = 1'b1;
                for (int i = 0; i < int'(ND); i++) begin
                    if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
                end
                {bcd_nxt, mag_nxt} = {bcd_adj, mag_q} << 1;
                cnt_nxt = cnt_q + CW'(1);
                if (cnt_q == CW'(DW - 1)) begin
                    state_nxt = S_LATCH;
                    cnt_nxt   = '0;
                end
            end
            S_LATCH: begin
`ifdef SEQ_BCD_LZB_EN
                // Blank every digit above the most significant nonzero one; units always shows.
                for (int i = int'(ND) - 1; i >= 1; i--) begin
                    if (bcd_q[4*i +: 4] != 4'd0) lz_run = 1'b0;
                    lzb_blank[i] = lz_run;
                end
`endif
                for (int i = 0; i < int'(ND); i++) begin
                    dig  = bcd_q[4*i +: 4];
                    code = lzb_blank[i] ? SEG_BLANK : seg_enc(dig);
                    seg_nxt[7*i +: 7] = seg_pol(code);
                end
                sign_seg_nxt = seg_pol(sign_q ? SEG_MINUS : SEG_BLANK);
                done_nxt     = 1'b1;
                busy_nxt     = 1'b0;
                state_nxt    = S_IDLE;
                accept       = bus.i_start;
            end
            default: begin
                state_nxt = S_IDLE;
                busy_nxt  = 1'b0;
            end
        endcase

        // Capture a new request; back-to-back from LATCH keeps the throughput at DW+1
        if (accept) begin
            sign_nxt  = bus.i_bin[DW-1];
            mag_nxt   = bus.i_bin[DW-1] ? DW'(-bus.i_bin) : bus.i_bin;
            bcd_nxt   = '0;
            cnt_nxt   = '0;
            busy_nxt  = 1'b1;
            state_nxt = S_CONV;
        end
    end

    assign bus.o_busy     = busy_q;
    assign bus.o_done     = done_q;
    assign bus.o_seg      = seg_q;
    assign bus.o_sign_seg = sign_seg_q;
endmodule

// File: tb/tb_seq_bcd_display.sv
// Directed self-checking bench for seq_bcd_display (DW=8, ND=3, active-low segments).
module tb_seq_bcd_display;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    seq_bcd_display_if #(.DW(8), .ND(3)) bus ();

    seq_bcd_display #(.DW(8), .ND(3), .SEG_ACTIVE_LOW(1'b1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Active-low digit codes
    localparam logic [6:0] D0 = 7'h40, D1 = 7'h79, D2 = 7'h24, D4 = 7'h19;
    localparam logic [6:0] D5 = 7'h12, D7 = 7'h78, D8 = 7'h00, BL = 7'h7F, MI = 7'h3F;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    // Pulse i_start for one edge; returns sitting just after the accepting edge.
    task automatic pulse_start(input logic [7:0] v);
        @(negedge clk);
        bus.i_start = 1'b1;
        bus.i_bin   = v;
        @(negedge clk);
        bus.i_start = 1'b0;
    endtask

    task automatic convert(input logic [7:0] v, output int lat);
        bit found;
        pulse_start(v);
        lat   = 0;
        found = 1'b0;
        for (int n = 1; n <= 30 && !found; n++) begin
            @(negedge clk);
            if (bus.o_done) begin
                lat   = n;
                found = 1'b1;
            end
        end
    endtask

    initial begin
        int lat;
        int busy_cnt;
        int done_cnt;
        logic [20:0] exp_seg;

        checks      = 0;
        errors      = 0;
        rst         = 1'b0;
        bus.i_start = 1'b0;
        bus.i_bin   = 8'd0;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(bus.o_busy), 32'd0);
        check("rst_done", 32'(bus.o_done), 32'd0);
        check("rst_seg", 32'(bus.o_seg), 32'h1FFFFF);
        check("rst_sign", 32'(bus.o_sign_seg), 32'h7F);
        rst = 1'b1;
        @(negedge clk);

        // 127: latency and one-cycle done
        convert(8'd127, lat);
        check("p127_lat", 32'(lat), 32'd9);
        check("p127_seg", 32'(bus.o_seg), 32'({D1, D2, D7}));
        check("p127_sign", 32'(bus.o_sign_seg), 32'(BL));
        check("p127_busy", 32'(bus.o_busy), 32'd0);
        @(negedge clk);
        check("p127_done_off", 32'(bus.o_done), 32'd0);

        // Most negative value
        convert(8'h80, lat);
        check("m128_lat", 32'(lat), 32'd9);
        check("m128_seg", 32'(bus.o_seg), 32'({D1, D2, D8}));
        check("m128_sign", 32'(bus.o_sign_seg), 32'(MI));

        // -5
        convert(8'hFB, lat);
`ifdef SEQ_BCD_LZB_EN
        exp_seg = {BL, BL, D5};
`else
        exp_seg = {D0, D0, D5};
`endif
        check("m5_seg", 32'(bus.o_seg), 32'(exp_seg));
        check("m5_sign", 32'(bus.o_sign_seg), 32'(MI));

        // Zero is never negative
        convert(8'd0, lat);
`ifdef SEQ_BCD_LZB_EN
        exp_seg = {BL, BL, D0};
`else
        exp_seg = {D0, D0, D0};
`endif
        check("zero_seg", 32'(bus.o_seg), 32'(exp_seg));
        check("zero_sign", 32'(bus.o_sign_seg), 32'(BL));

        // 42 with an ignored 99 request three cycles in
        pulse_start(8'd42);
        busy_cnt = bus.o_busy ? 1 : 0;
        done_cnt = 0;
        check("hold_seg", 32'(bus.o_seg), 32'(exp_seg));
        for (int k = 1; k <= 12; k++) begin
            bus.i_start = (k == 3);
            if (k == 3) bus.i_bin = 8'd99;
            @(negedge clk);
            if (bus.o_busy) busy_cnt++;
            if (bus.o_done) done_cnt++;
        end
        bus.i_start = 1'b0;
`ifdef SEQ_BCD_LZB_EN
        exp_seg = {BL, D4, D2};
`else
        exp_seg = {D0, D4, D2};
`endif
        check("ign_busy_cycles", 32'(busy_cnt), 32'd9);
        check("ign_done_count", 32'(done_cnt), 32'd1);
        check("ign_seg", 32'(bus.o_seg), 32'(exp_seg));
        check("ign_sign", 32'(bus.o_sign_seg), 32'(BL));

        // Asynchronous abort four cycles into a 99 conversion
        pulse_start(8'd99);
        done_cnt = 0;
        repeat (3) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("abort_seg", 32'(bus.o_seg), 32'h1FFFFF);
        check("abort_sign", 32'(bus.o_sign_seg), 32'h7F);
        check("abort_busy", 32'(bus.o_busy), 32'd0);
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (bus.o_done) done_cnt++;
        end
        rst = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (bus.o_done) done_cnt++;
        end
        check("abort_no_done", 32'(done_cnt), 32'd0);

        convert(8'd7, lat);
`ifdef SEQ_BCD_LZB_EN
        exp_seg = {BL, BL, D7};
`else
        exp_seg = {D0, D0, D7};
`endif
        check("post_lat", 32'(lat), 32'd9);
        check("post_seg", 32'(bus.o_seg), 32'(exp_seg));
        check("post_sign", 32'(bus.o_sign_seg), 32'(BL));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
